// File: rtl/mem_handshake_ram.sv
// Byte-addressed big-endian RAM with programmable wait states, answering
// MOV/R_W requests through a four-phase MOV/MOC handshake.
module mem_handshake_ram #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MOV,
    input  logic        R_W,
    input  logic [1:0]  Size,
    input  logic [31:0] Address,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        Err,
    output logic        Busy
);
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              moc_q, moc_d;
    logic              err_q, err_d;
    logic [31:0]       dout_q, dout_d;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              rw_q;

    logic              capture, access, fault, wr_en;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       rd_data;
    logic [7:0]        mem [DEPTH];

    // Upper address bits are intentionally dropped: the array aliases.
    logic unused_addr;
    assign unused_addr = ^Address[31:ADDR_W];

    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

    always_comb begin
        case (size_q)
            SZ_BYTE: fault = 1'b0;
            SZ_HALF: fault = addr_q[0];
            SZ_WORD: fault = (addr_q[1:0] != 2'b00);
            default: fault = 1'b1;
        endcase
    end

    always_comb begin
        case (size_q)
            SZ_BYTE: rd_data = {24'h0, mem[a0]};
            SZ_HALF: rd_data = {16'h0, mem[a0], mem[a1]};
            default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        moc_d   = moc_q;
        err_d   = err_q;
        dout_d  = dout_q;
        capture = 1'b0;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    capture = 1'b1;
                    cnt_d   = WAIT_LD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    moc_d   = 1'b1;
                    err_d   = fault;
                    state_d = S_DONE;
                    // Faulted accesses of either direction zero the read bus.
                    if (fault)     dout_d = 32'h0;
                    else if (rw_q) dout_d = rd_data;
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr_en = access && !rw_q && !fault;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            moc_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            moc_q   <= moc_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (capture) begin
            addr_q  <= Address[ADDR_W-1:0];
            wdata_q <= DataIn;
            size_q  <= Size;
            rw_q    <= R_W;
        end
    end

    // Array is not cleared by reset; reset only blocks an in-flight write.
    always_ff @(posedge Clk) begin
        if (Reset && wr_en) begin
            case (size_q)
                SZ_BYTE: mem[a0] <= wdata_q[7:0];
                SZ_HALF: begin
                    mem[a0] <= wdata_q[15:8];
                    mem[a1] <= wdata_q[7:0];
                end
                SZ_WORD: begin
                    mem[a0] <= wdata_q[31:24];
                    mem[a1] <= wdata_q[23:16];
                    mem[a2] <= wdata_q[15:8];
                    mem[a3] <= wdata_q[7:0];
                end
                default: ;
            endcase
        end
    end

    assign DataOut = dout_q;
    assign MOC     = moc_q;
    assign Err     = err_q;
    assign Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Bench for mem_handshake_ram: table of request vectors checked through an
// expected-result queue, plus hand sequences for handshake and reset corners.
module tb_mem_handshake_ram;
    localparam int AW = 9;
    localparam int WC = 2;

    logic        Clk = 1'b0;
    logic        Reset, MOV, R_W;
    logic [1:0]  Size;
    logic [31:0] Address, DataIn, DataOut;
    logic        MOC, Err, Busy;

    int n_chk  = 0;
    int n_pass = 0;

    mem_handshake_ram #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .Clk(Clk), .Reset(Reset), .MOV(MOV), .R_W(R_W), .Size(Size),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut),
        .MOC(MOC), .Err(Err), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] dout;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present a request and return just after the capturing edge, scrambling
    // the inputs so a late re-sample would be visible.
    task automatic issue(input vec_t v);
        @(negedge Clk);
        MOV = 1'b1; R_W = v.rw; Size = v.size; Address = v.addr; DataIn = v.din;
        @(posedge Clk); #1;
        R_W = 1'($urandom); Size = 2'($urandom);
        Address = $urandom; DataIn = $urandom;
    endtask

    task automatic wait_moc(output int lat);
        lat = 0;
        while (MOC !== 1'b1 && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, " sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({name, " dout"}, DataOut, e.dout);
            check({name, " err"}, 32'(Err), 32'(e.err));
        end
    endtask

    task automatic release_mov(input string name);
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
        check({name, " moc_fall"}, 32'(MOC), 32'd0);
        check({name, " err_fall"}, 32'(Err), 32'd0);
        check({name, " idle"}, 32'(Busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        issue(v);
        sb.push_back('{v.exp_dout, v.exp_err});
        wait_moc(lat);
        check({name, " latency"}, 32'(lat), 32'(WC + 1));
        check({name, " busy"}, 32'(Busy), 32'd1);
        pop_check(name);
        release_mov(name);
    endtask

    initial begin
        int   lat;
        logic seen;
        vec_t v;

        tbl[0]  = '{1'b0, 2'b10, 32'h0000_0010, 32'hA1B2C3D4, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b1, 2'b00, 32'h0000_0010, 32'h0,        32'h0000_00A1, 1'b0};
        tbl[2]  = '{1'b1, 2'b00, 32'h0000_0011, 32'h0,        32'h0000_00B2, 1'b0};
        tbl[3]  = '{1'b1, 2'b00, 32'h0000_0012, 32'h0,        32'h0000_00C3, 1'b0};
        tbl[4]  = '{1'b1, 2'b00, 32'h0000_0013, 32'h0,        32'h0000_00D4, 1'b0};
        tbl[5]  = '{1'b1, 2'b10, 32'h0000_0010, 32'h0,        32'hA1B2C3D4, 1'b0};
        tbl[6]  = '{1'b1, 2'b01, 32'h0000_0012, 32'h0,        32'h0000_C3D4, 1'b0};
        tbl[7]  = '{1'b0, 2'b01, 32'h0000_0022, 32'h0000BEEF, 32'h0000_C3D4, 1'b0};
        tbl[8]  = '{1'b0, 2'b01, 32'h0000_0020, 32'h00001234, 32'h0000_C3D4, 1'b0};
        tbl[9]  = '{1'b1, 2'b10, 32'h0000_0020, 32'h0,        32'h1234BEEF, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 32'h0000_0023, 32'h0000005A, 32'h1234BEEF, 1'b0};
        tbl[11] = '{1'b1, 2'b01, 32'h0000_0022, 32'h0,        32'h0000_BE5A, 1'b0};
        tbl[12] = '{1'b0, 2'b10, 32'h0000_0030, 32'hCAFEF00D, 32'h0000_BE5A, 1'b0};
        tbl[13] = '{1'b1, 2'b10, 32'h0000_0021, 32'h0,        32'h0000_0000, 1'b1};
        tbl[14] = '{1'b0, 2'b01, 32'h0000_0031, 32'h0000FFFF, 32'h0000_0000, 1'b1};
        tbl[15] = '{1'b1, 2'b11, 32'h0000_0030, 32'h0,        32'h0000_0000, 1'b1};
        tbl[16] = '{1'b1, 2'b10, 32'h0000_0030, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[17] = '{1'b0, 2'b10, 32'hFFFF_FE04, 32'h11223344, 32'hCAFEF00D, 1'b0};
        tbl[18] = '{1'b1, 2'b10, 32'h0000_0004, 32'h0,        32'h11223344, 1'b0};
        tbl[19] = '{1'b0, 2'b00, 32'h0000_01FF, 32'h00000077, 32'h11223344, 1'b0};
        tbl[20] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'h0,        32'h0000_0077, 1'b0};
        tbl[21] = '{1'b0, 2'b10, 32'h0000_0040, 32'hDEADBEEF, 32'h0000_0077, 1'b0};
        tbl[22] = '{1'b1, 2'b10, 32'h0000_0040, 32'h0,        32'hDEADBEEF, 1'b0};

        // Reset held for two edges while a request is offered.
        Reset = 1'b0; MOV = 1'b1; R_W = 1'b1; Size = 2'b10;
        Address = 32'h10; DataIn = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst moc", 32'(MOC), 32'd0);
        check("rst err", 32'(Err), 32'd0);
        check("rst busy", 32'(Busy), 32'd0);
        check("rst dout", DataOut, 32'h0);
        @(negedge Clk);
        Reset = 1'b1; MOV = 1'b0;
        @(posedge Clk); #1;
        check("rst no_capture", 32'(Busy), 32'd0);

        for (int i = 0; i < 23; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // MOV dropped during WAIT: access completes, MOC pulses one cycle.
        v = '{1'b1, 2'b10, 32'h10, 32'h0, 32'hA1B2C3D4, 1'b0};
        issue(v);
        sb.push_back('{v.exp_dout, v.exp_err});
        MOV = 1'b0;
        wait_moc(lat);
        check("drop latency", 32'(lat), 32'(WC + 1));
        pop_check("drop");
        @(posedge Clk); #1;
        check("drop moc_pulse", 32'(MOC), 32'd0);
        check("drop idle", 32'(Busy), 32'd0);

        // MOV held after MOC: MOC stays up, then new request after MOV low.
        v = '{1'b1, 2'b01, 32'h22, 32'h0, 32'h0000BE5A, 1'b0};
        issue(v);
        sb.push_back('{v.exp_dout, v.exp_err});
        wait_moc(lat);
        check("hold latency", 32'(lat), 32'(WC + 1));
        pop_check("hold");
        seen = 1'b1;
        repeat (5) begin
            @(posedge Clk); #1;
            seen &= MOC;
        end
        check("hold moc_held", 32'(seen), 32'd1);
        @(negedge Clk);
        MOV = 1'b0;
        @(posedge Clk); #1;
        check("hold moc_fall", 32'(MOC), 32'd0);
        MOV = 1'b1; R_W = 1'b1; Size = 2'b00; Address = 32'h13;
        sb.push_back('{32'h000000D4, 1'b0});
        @(posedge Clk); #1;
        check("rearm captured", 32'(Busy), 32'd1);
        wait_moc(lat);
        check("rearm latency", 32'(lat), 32'(WC + 1));
        pop_check("rearm");
        release_mov("rearm");

        // Reset pulsed during WAIT aborts the write.
        v = '{1'b0, 2'b10, 32'h40, 32'h55667788, 32'h0, 1'b0};
        issue(v);
        @(posedge Clk); #1;
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("abort moc", 32'(MOC), 32'd0);
        check("abort busy", 32'(Busy), 32'd0);
        check("abort dout", DataOut, 32'h0);
        @(negedge Clk);
        Reset = 1'b1; MOV = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge Clk); #1;
            seen |= MOC;
        end
        check("abort no_moc", 32'(seen), 32'd0);
        run_vec('{1'b1, 2'b10, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0}, "abort readback");

        check("sb drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
